// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave in front of a word-organised on-chip SRAM.
// Wait-state count is a parameter; errors get the standard two-cycle response.
module ahb_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        Rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    logic [31:0]   mem [MEM_WORDS];
    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          accept;
    logic          addr_err;
    logic [3:0]    be;
    logic          unused_htrans;

    // Only NONSEQ/SEQ start a transfer; HTRANS[0] carries no meaning here
    assign unused_htrans = HTRANS[0];
    assign accept = HSEL & HTRANS[1] & HREADY;

    // Classify the incoming address phase as erroneous or not
    always_comb begin
        addr_err = 1'b0;
        if (HSIZE > 3'd2)
            addr_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])
            addr_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
            addr_err = 1'b1;
        if ({1'b0, HADDR} >= LIMIT)
            addr_err = 1'b1;
    end

    // Byte-lane enables of the latched transfer
    always_comb begin
        be = 4'b1111;
        unique case (size_q)
            2'd0:    be = 4'b0001 << off_q;
            2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Data-phase sequencer with registered handshake outputs
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            cnt       <= 4'd0;
            idx_q     <= '0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            write_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_DONE;
                        HREADYOUT <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        idx_q   <= HADDR[AW+1:2];
                        off_q   <= HADDR[1:0];
                        size_q  <= HSIZE[1:0];
                        write_q <= HWRITE;
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                            cnt       <= WS_LOAD;
                        end else begin
                            state     <= ST_DONE;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Commit write data on the edge that closes the data phase
    always_ff @(posedge clock) begin
        if (state == ST_DONE && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Read data is only driven during a read data phase
    assign HRDATA = ((state == ST_WAIT || state == ST_DONE) && !write_q)
                    ? mem[idx_q] : 32'd0;

endmodule
